// File: rtl/cpu_pkg.sv
`default_nettype none
//======================================================================
// Module   : cpu_pkg
// Brief    : Shared types for the instruction-fetch stage. The entry gains
//            a fault bit when CPU_IF_ALIGN_CHECK_EN is defined.
// Revision : 1.0  initial release
//======================================================================
package cpu_pkg;

   localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
`ifdef CPU_IF_ALIGN_CHECK_EN
      logic        fault;
`endif
   } fetch_entry_t;

   localparam int c_ENTRY_W = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/cpu_fetch_fifo.sv
`default_nettype none
//======================================================================
// Module   : cpu_fetch_fifo
// Brief    : Synchronous FIFO with push/pop/flush and occupancy count.
//            Entry width follows CPU_IF_ALIGN_CHECK_EN via the caller.
// Revision : 1.0  initial release
//======================================================================
module cpu_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       push_data,
   output logic [WIDTH-1:0]       head_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int                c_PTR_W    = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]  c_FULL_CNT = DEPTH[c_PTR_W:0];

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_full;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_full    = (r_count == c_FULL_CNT);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head_data = r_mem[r_rd_ptr];

   // flush wins over any push or pop in the same cycle
   assign w_do_push = push && !w_full && !flush;
   assign w_do_pop  = pop && !empty && !flush;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cpu_instruction_fetch.sv
`default_nettype none
//======================================================================
// Module   : cpu_instruction_fetch
// Brief    : PC, single-outstanding imem fetch, prefetch FIFO to decode.
//            CPU_IF_ALIGN_CHECK_EN adds output_fault and misalignment trap.
// Revision : 1.0  initial release
//======================================================================
module cpu_instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = c_RESET_PC,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] PC_STEP    = 32'd4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] output_address,
   output logic [31:0] output_instruction,
   output logic        output_valid,
   input  logic        output_full
`ifdef CPU_IF_ALIGN_CHECK_EN
   ,
   output logic        output_fault
`endif
);

   localparam int                 c_CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH = FIFO_DEPTH[c_CNT_W-1:0];

   fetch_state_t       r_state;
   fetch_state_t       w_state_nxt;
   logic [31:0]        r_pc;
   logic [31:0]        w_pc_nxt;
   logic [31:0]        r_req_addr;
   logic [31:0]        w_req_addr_nxt;
   logic               r_drop;
   logic               w_drop_nxt;
   logic               r_halt;
   logic               w_halt_nxt;
   logic               w_push;
   logic               w_pop;
   logic               w_empty;
   logic               w_credit;
   logic               w_misaligned;
   logic [c_CNT_W-1:0] w_count;
   logic [c_CNT_W-1:0] w_used;
   fetch_entry_t       w_push_entry;
   fetch_entry_t       w_head_entry;

   // an outstanding request owns a slot, so a response can always be pushed
   assign w_used   = w_count + {{(c_CNT_W-1){1'b0}}, (r_state == S_WAIT)};
   assign w_credit = (w_used < c_DEPTH);

`ifdef CPU_IF_ALIGN_CHECK_EN
   assign w_misaligned = (r_pc[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   assign imem_addr = r_pc;

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_addr_nxt = r_req_addr;
      w_drop_nxt     = r_drop;
      w_halt_nxt     = r_halt;
      imem_req       = 1'b0;
      w_push         = 1'b0;
      w_push_entry   = '0;

      case (r_state)
         S_IDLE: begin
            if (w_credit && !r_halt) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (w_misaligned) begin
               // trap entry replaces the fetch; wait for a redirect
               w_push            = 1'b1;
               w_push_entry.addr = r_pc;
`ifdef CPU_IF_ALIGN_CHECK_EN
               w_push_entry.fault = 1'b1;
`endif
               w_halt_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  w_req_addr_nxt = r_pc;
                  w_pc_nxt       = r_pc + PC_STEP;
                  w_state_nxt    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               w_drop_nxt = 1'b0;
               if (r_drop) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_push             = 1'b1;
                  w_push_entry.addr  = r_req_addr;
                  w_push_entry.instr = imem_rdata;
                  w_state_nxt        = w_credit ? S_REQ : S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (redirect_valid) begin
         w_pc_nxt   = redirect_target;
         w_halt_nxt = 1'b0;
         w_push     = 1'b0;
         case (r_state)
            S_WAIT: begin
               // one outstanding request at most, so a single drop flag suffices
               w_drop_nxt  = !imem_rvalid;
               w_state_nxt = imem_rvalid ? S_REQ : S_WAIT;
            end
            S_REQ: begin
               if (imem_req && imem_ready) begin
                  w_drop_nxt  = 1'b1;
                  w_state_nxt = S_WAIT;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
            default: begin
               w_state_nxt = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_req_addr <= '0;
         r_drop     <= 1'b0;
         r_halt     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req_addr <= w_req_addr_nxt;
         r_drop     <= w_drop_nxt;
         r_halt     <= w_halt_nxt;
      end
   end

   assign w_pop = output_valid && !output_full && !redirect_valid;

   cpu_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_ENTRY_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .pop       (w_pop),
      .flush     (redirect_valid),
      .push_data (w_push_entry),
      .head_data (w_head_entry),
      .empty     (w_empty),
      .count     (w_count)
   );

   assign output_valid       = !w_empty;
   assign output_address     = output_valid ? w_head_entry.addr  : 32'h0;
   assign output_instruction = output_valid ? w_head_entry.instr : 32'h0;
`ifdef CPU_IF_ALIGN_CHECK_EN
   assign output_fault       = output_valid ? w_head_entry.fault : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_instruction_fetch.sv
`default_nettype none
//======================================================================
// Module   : tb_cpu_instruction_fetch
// Brief    : Directed self-checking bench for cpu_instruction_fetch;
//            alignment scenario runs when CPU_IF_ALIGN_CHECK_EN is defined.
// Revision : 1.0  initial release
//======================================================================
module tb_cpu_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] output_address;
   logic [31:0] output_instruction;
   logic        output_valid;
   logic        output_full;
`ifdef CPU_IF_ALIGN_CHECK_EN
   logic        output_fault;
`endif

   int errors = 0;
   int checks = 0;

   int          mem_lat;
   bit          pend;
   int          cd;
   logic [31:0] paddr;
   bit          stale_en;
   logic [31:0] stale_val;

   cpu_instruction_fetch dut (
      .clock              (clock),
      .reset              (reset),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_ready         (imem_ready),
      .imem_rvalid        (imem_rvalid),
      .imem_rdata         (imem_rdata),
      .redirect_valid     (redirect_valid),
      .redirect_target    (redirect_target),
      .output_address     (output_address),
      .output_instruction (output_instruction),
      .output_valid       (output_valid),
      .output_full        (output_full)
`ifdef CPU_IF_ALIGN_CHECK_EN
      ,
      .output_fault       (output_fault)
`endif
   );

   always #5 clock = ~clock;

   // memory contents: word at address a is a ^ 5A5AA5A5
   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // one clock: inputs are set at the falling edge, memory answers after
   // mem_lat cycles, outputs are then observed at the next falling edge
   task automatic step();
      logic        acc;
      logic [31:0] aaddr;
      acc   = imem_req && imem_ready && reset;
      aaddr = imem_addr;
      @(posedge clock);
      @(negedge clock);
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      if (acc) begin
         pend  = 1'b1;
         cd    = mem_lat;
         paddr = aaddr;
      end
      if (pend) begin
         if (cd <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = stale_en ? stale_val : mdata(paddr);
            stale_en    = 1'b0;
            pend        = 1'b0;
         end else begin
            cd--;
         end
      end
   endtask

   task automatic apply_reset();
      reset = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      output_full = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      mem_lat = 1; pend = 1'b0; cd = 0; stale_en = 1'b0; stale_val = 32'h0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      output_full = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      mem_lat = 1; pend = 1'b0; cd = 0; stale_en = 1'b0; stale_val = 32'h0;
      @(negedge clock);
      @(negedge clock);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", output_valid); end
      checks++; if (output_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", output_address); end
      checks++; if (output_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", output_instruction); end
      checks++; if (imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_pc: got %h want bfc00000", imem_addr); end
`ifdef CPU_IF_ALIGN_CHECK_EN
      checks++; if (output_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", output_fault); end
`endif
      reset = 1'b1;
   endtask

   task automatic test_stream();
      bit          ev  [7] = '{0, 0, 1, 0, 1, 0, 1};
      bit          er  [7] = '{1, 0, 1, 0, 1, 0, 1};
      logic [31:0] ea  [7] = '{32'h0, 32'h0, 32'hBFC0_0000, 32'h0, 32'hBFC0_0004, 32'h0, 32'hBFC0_0008};
      logic [31:0] ei  [7] = '{32'h0, 32'h0, 32'hE59A_A5A5, 32'h0, 32'hE59A_A5A1, 32'h0, 32'hE59A_A5AD};
      logic [31:0] eia [7] = '{32'hBFC0_0000, 32'h0, 32'hBFC0_0004, 32'h0, 32'hBFC0_0008, 32'h0, 32'hBFC0_000C};
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         step();
         checks++; if (output_valid !== ev[i]) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", i, output_valid, ev[i]); end
         checks++; if (imem_req !== er[i]) begin errors++; $display("FAIL stream_req[%0d]: got %b want %b", i, imem_req, er[i]); end
         if (er[i]) begin
            checks++; if (imem_addr !== eia[i]) begin errors++; $display("FAIL stream_imem_addr[%0d]: got %h want %h", i, imem_addr, eia[i]); end
         end
         if (ev[i]) begin
            checks++; if (output_address !== ea[i]) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, output_address, ea[i]); end
            checks++; if (output_instruction !== ei[i]) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, output_instruction, ei[i]); end
         end
      end
   endtask

   task automatic test_backpressure();
      bit          ev [14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
      bit          er [14] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
      logic [31:0] ea [14] = '{32'h0, 32'h0, 32'hBFC0_0000, 32'hBFC0_0000, 32'hBFC0_0000,
                               32'hBFC0_0000, 32'hBFC0_0000, 32'hBFC0_0000, 32'hBFC0_0000,
                               32'hBFC0_0000, 32'hBFC0_0004, 32'h0, 32'h0, 32'hBFC0_0008};
      logic [31:0] ei [14] = '{32'h0, 32'h0, 32'hE59A_A5A5, 32'hE59A_A5A5, 32'hE59A_A5A5,
                               32'hE59A_A5A5, 32'hE59A_A5A5, 32'hE59A_A5A5, 32'hE59A_A5A5,
                               32'hE59A_A5A5, 32'hE59A_A5A1, 32'h0, 32'h0, 32'hE59A_A5AD};
      apply_reset();
      for (int i = 0; i < 14; i++) begin
         output_full = (i < 10);
         step();
         checks++; if (output_valid !== ev[i]) begin errors++; $display("FAIL bp_valid[%0d]: got %b want %b", i, output_valid, ev[i]); end
         checks++; if (imem_req !== er[i]) begin errors++; $display("FAIL bp_req[%0d]: got %b want %b", i, imem_req, er[i]); end
         if (ev[i]) begin
            checks++; if (output_address !== ea[i]) begin errors++; $display("FAIL bp_addr[%0d]: got %h want %h", i, output_address, ea[i]); end
            checks++; if (output_instruction !== ei[i]) begin errors++; $display("FAIL bp_instr[%0d]: got %h want %h", i, output_instruction, ei[i]); end
         end
      end
   endtask

   task automatic test_redirect_wait();
      apply_reset();
      mem_lat = 3;
      step();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_req_first: got %b want 1", imem_req); end
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_in_wait: got %b want 0", imem_req); end
      redirect_valid = 1'b1; redirect_target = 32'h8000_1000;
      stale_en = 1'b1; stale_val = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_hidden[%0d]: got valid %b instr %h want valid 0", i, output_valid, output_instruction); end
      end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_resume_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h8000_1000) begin errors++; $display("FAIL rw_resume_addr: got %h want 80001000", imem_addr); end
      mem_lat = 1;
      step();
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rw_gap: got %b want 0", output_valid); end
      step();
      checks++; if (output_valid !== 1'b1) begin errors++; $display("FAIL rw_valid: got %b want 1", output_valid); end
      checks++; if (output_address !== 32'h8000_1000) begin errors++; $display("FAIL rw_addr: got %h want 80001000", output_address); end
      checks++; if (output_instruction !== 32'hDA5A_B5A5) begin errors++; $display("FAIL rw_instr: got %h want da5ab5a5", output_instruction); end
   endtask

   task automatic test_redirect_ready_pop();
      apply_reset();
      step(); step(); step();
      checks++; if (output_valid !== 1'b1) begin errors++; $display("FAIL rr_pre_valid: got %b want 1", output_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rr_pre_req: got %b want 1", imem_req); end
      redirect_valid = 1'b1; redirect_target = 32'h8000_1000;
      step();
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rr_flushed: got %b want 0", output_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rr_wait_req: got %b want 0", imem_req); end
      step();
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rr_dropped: got %b want 0", output_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rr_resume_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h8000_1000) begin errors++; $display("FAIL rr_resume_addr: got %h want 80001000", imem_addr); end
      step();
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rr_gap: got %b want 0", output_valid); end
      step();
      checks++; if (output_address !== 32'h8000_1000 || output_valid !== 1'b1) begin errors++; $display("FAIL rr_first: got %b/%h want 1/80001000", output_valid, output_address); end
      checks++; if (output_instruction !== 32'hDA5A_B5A5) begin errors++; $display("FAIL rr_first_instr: got %h want da5ab5a5", output_instruction); end
      checks++; if (imem_addr !== 32'h8000_1004) begin errors++; $display("FAIL rr_next_pc: got %h want 80001004", imem_addr); end
      step(); step();
      checks++; if (output_address !== 32'h8000_1004 || output_valid !== 1'b1) begin errors++; $display("FAIL rr_second: got %b/%h want 1/80001004", output_valid, output_address); end
      checks++; if (output_instruction !== 32'hDA5A_B5A1) begin errors++; $display("FAIL rr_second_instr: got %h want da5ab5a1", output_instruction); end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      step(); step(); step();
      output_full = 1'b1;
      mem_lat = 4;
      step();
      checks++; if (output_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL rm_pre: got valid %b req %b want 1 0", output_valid, imem_req); end
      stale_en = 1'b1; stale_val = 32'hDEAD_BEEF;
      reset = 1'b0;
      #1;
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", output_valid); end
      checks++; if (output_address !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h want 00000000", output_address); end
      checks++; if (output_instruction !== 32'h0) begin errors++; $display("FAIL rm_instr: got %h want 00000000", output_instruction); end
      checks++; if (imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rm_pc: got %h want bfc00000", imem_addr); end
      step();
      reset = 1'b1; imem_ready = 1'b0; output_full = 1'b0;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rm_first_req: got %b/%h want 1/bfc00000", imem_req, imem_addr); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rm_late_ignored[%0d]: got %b want 0", i, output_valid); end
      end
      imem_ready = 1'b1; mem_lat = 1;
      step(); step();
      checks++; if (output_valid !== 1'b1 || output_address !== 32'hBFC0_0000) begin errors++; $display("FAIL rm_refetch: got %b/%h want 1/bfc00000", output_valid, output_address); end
      checks++; if (output_instruction !== 32'hE59A_A5A5) begin errors++; $display("FAIL rm_refetch_instr: got %h want e59aa5a5", output_instruction); end
   endtask

`ifdef CPU_IF_ALIGN_CHECK_EN
   task automatic test_align();
      apply_reset();
      redirect_valid = 1'b1; redirect_target = 32'h8000_0002;
      step();
      checks++; if (imem_req !== 1'b0 || output_valid !== 1'b0) begin errors++; $display("FAIL al_no_req: got req %b valid %b want 0 0", imem_req, output_valid); end
      step();
      checks++; if (output_valid !== 1'b1 || output_fault !== 1'b1) begin errors++; $display("FAIL al_fault: got valid %b fault %b want 1 1", output_valid, output_fault); end
      checks++; if (output_address !== 32'h8000_0002 || output_instruction !== 32'h0) begin errors++; $display("FAIL al_entry: got %h/%h want 80000002/00000000", output_address, output_instruction); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL al_req2: got %b want 0", imem_req); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (imem_req !== 1'b0 || output_valid !== 1'b0) begin errors++; $display("FAIL al_halted[%0d]: got req %b valid %b want 0 0", i, imem_req, output_valid); end
      end
      redirect_valid = 1'b1; redirect_target = 32'h8000_0000;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL al_resume: got %b/%h want 1/80000000", imem_req, imem_addr); end
      step(); step();
      checks++; if (output_valid !== 1'b1 || output_address !== 32'h8000_0000 || output_fault !== 1'b0) begin errors++; $display("FAIL al_normal: got %b/%h/%b want 1/80000000/0", output_valid, output_address, output_fault); end
      checks++; if (output_instruction !== 32'hDA5A_A5A5) begin errors++; $display("FAIL al_normal_instr: got %h want da5aa5a5", output_instruction); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_ready_pop();
      test_reset_mid_wait();
`ifdef CPU_IF_ALIGN_CHECK_EN
      test_align();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
